ddr_test_sequencer: RTL and testbench
=====================================

Name: ddr_test_sequencer

Overview:
- Top-level controller for the DDR4 traffic test.
- Sequences the AXI write stream generator, then a read/compare generator with the same control interface, over a configurable number of iterations × streams × bursts.
- Owns generator enables, burst addresses, stream/iteration tags and burst length; collects completion, error and timeout status for the host/VIO.

Parameters:
- ADDR_W, 32, AXI byte-address width
- BEAT_BYTES_LOG2, 6, bytes per beat as log2 (512-bit data = 64 B)
- TIMEOUT_CYC, 4096, max cycles between consecutive generator finish pulses before fault
- ERR_CNT_W, 16, error counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE/DONE/FAULT
- base_addr  in  ADDR_W  first burst address, sampled at start
- num_iters  in  8  iteration count (0 treated as 1), sampled at start
- num_streams  in  8  streams per iteration (0 treated as 1), sampled at start
- bursts_per_stream  in  16  bursts per stream (0 treated as 1), sampled at start
- burst_len_cfg  in  8  beats per burst (1..255; 0 treated as 1), sampled at start
- wr_en  out  1  write generator enable
- wr_adr_neg  in  1  write AW handshake pulse
- wr_finish  in  1  write B handshake pulse
- rd_en  out  1  read generator enable
- rd_adr_neg  in  1  read AR handshake pulse
- rd_finish  in  1  read burst complete pulse
- rd_error  in  1  data mismatch pulse from read checker
- gen_addr  out  ADDR_W  address for current burst (shared by both generators)
- iter_num  out  8  current iteration tag
- stream_num  out  8  current stream tag
- burst_length  out  8  beats per burst
- busy  out  1  run in progress
- done  out  1  sticky; run completed
- error  out  1  sticky; at least one rd_error
- timeout  out  1  sticky; watchdog fired
- err_count  out  ERR_CNT_W  saturating mismatch count

Behaviour:
- Reset: state IDLE; all outputs 0; gen_addr 0; config registers 0.
- States: IDLE, WR_RUN, RD_RUN, NEXT, DONE, FAULT.
- IDLE/DONE/FAULT + start:
  - latch config; clear done, error, timeout, err_count
  - iter=0, stream=0, gen_addr=base_addr
  - go to WR_RUN next cycle
- WR_RUN:
  - wr_en is registered high throughout.
  - Each wr_adr_neg: gen_addr += burst_len << BEAT_BYTES_LOG2 (mod 2^ADDR_W), effective from the next cycle; issued-burst counter +1.
  - Each wr_finish: done-burst counter +1.
  - Last burst (done-burst counter == bursts_per_stream-1): wr_en must be low in the same cycle as wr_finish, so the generator returns to idle and issues no extra burst. Required form: wr_en = wr_en_q & ~(last & wr_finish). This is a combinational path from wr_finish; no loop exists.
  - On last wr_finish: gen_addr is restored to the stream start address; go to RD_RUN.
- RD_RUN:
  - Identical rules using rd_en, rd_adr_neg, rd_finish, over the same addresses.
  - On last rd_finish: go to NEXT.
- NEXT (1 cycle):
  - stream+1; if it wraps past num_streams-1 then stream=0 and iter+1.
  - gen_addr continues from the last stream's end address; addresses are not reused across streams/iterations.
  - After the final iter/stream, go to DONE (done=1); otherwise go to WR_RUN.
  - Both enables are low for at least 1 cycle between streams, which resets the generators' data counters.
- iter_num, stream_num, burst_length are registered and stable throughout a stream.
- busy = state in {WR_RUN, RD_RUN, NEXT}.
- rd_error in any state other than IDLE:
  - error=1
  - err_count+1, saturating at all-ones
  - run continues
- Watchdog:
  - counter clears on any wr_finish/rd_finish and on state entry; counts in WR_RUN/RD_RUN.
  - When it reaches TIMEOUT_CYC: enables drop, timeout=1, go to FAULT. Only start or reset leaves FAULT.
- start while busy: ignored.
- Finish pulse outside the matching RUN state: ignored.
- Reset mid-run: enables low the next cycle; all state as at reset.

Decomposition:
- Shared package ddr_test_pkg: state encoding localparams, BEAT_BYTES_LOG2 default, config-zero-to-one clamp rule.
- One natural sub-module: burst_tracker. One instance per phase, with the enable/last-burst/issued/done counters and the combinational en gating; the top multiplexes the shared address.

Test Plan:
- iters=1, streams=1, bursts=4, len=16, base=0x1000: 4 wr_adr_neg at 0x1000, 0x1400, 0x1800, 0x1C00; wr_en low in 4th wr_finish cycle; 4 rd bursts at the same addresses; done=1, err_count=0.
- iters=2, streams=3, bursts=2, len=1: iter_num/stream_num sequence (0,0)…(1,2); gen_addr steps 0x40; both enables low ≥1 cycle at each stream boundary; exactly 12 write and 12 read bursts.
- rd_error pulsed 3 times during RD_RUN: error=1, err_count=3, run still reaches done.
- Withhold wr_finish after first adr_neg with TIMEOUT_CYC=64: timeout=1 at cycle 64, wr_en=0, state FAULT; new start recovers.
- base=0xFFFF_FF80, len=1, bursts=3: addresses 0xFFFF_FF80, 0xFFFF_FFC0, 0x0000_0000 (wrap).
- Reset asserted mid-WR_RUN, and start pulsed while busy: outputs return to reset values; start during busy causes no restart.

Source files
------------

// File: rtl/ddr_test_pkg.sv
// ddr_test_pkg: shared definitions for the DDR4 traffic test sequencer.
//   - sequencer state encoding
//   - default beat size (log2 bytes)
//   - clamp helpers: a zero count or length is treated as one
package ddr_test_pkg;

    localparam int unsigned BEAT_BYTES_LOG2_DEF = 6;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_WR_RUN_ENC = 3'd1;
    localparam logic [2:0] ST_RD_RUN_ENC = 3'd2;
    localparam logic [2:0] ST_NEXT_ENC   = 3'd3;
    localparam logic [2:0] ST_DONE_ENC   = 3'd4;
    localparam logic [2:0] ST_FAULT_ENC  = 3'd5;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE_ENC,
        StWrRun = ST_WR_RUN_ENC,
        StRdRun = ST_RD_RUN_ENC,
        StNext  = ST_NEXT_ENC,
        StDone  = ST_DONE_ENC,
        StFault = ST_FAULT_ENC
    } seq_state_e;

    function automatic logic [7:0] clamp8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    function automatic logic [15:0] clamp16(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/ddr_test_sequencer_if.sv
// ddr_test_sequencer_if: host configuration/status plus write/read generator handshakes.
//   master: the sequencer (drives enables, address, tags and status)
//   slave : host + generators (drive start, config, handshake pulses, rd_error)
interface ddr_test_sequencer_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ERR_CNT_W = 16
);
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [7:0]           num_iters;
    logic [7:0]           num_streams;
    logic [15:0]          bursts_per_stream;
    logic [7:0]           burst_len_cfg;
    logic                 wr_en;
    logic                 wr_adr_neg;
    logic                 wr_finish;
    logic                 rd_en;
    logic                 rd_adr_neg;
    logic                 rd_finish;
    logic                 rd_error;
    logic [ADDR_W-1:0]    gen_addr;
    logic [7:0]           iter_num;
    logic [7:0]           stream_num;
    logic [7:0]           burst_length;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic                 timeout;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        input  start, base_addr, num_iters, num_streams, bursts_per_stream, burst_len_cfg,
        input  wr_adr_neg, wr_finish, rd_adr_neg, rd_finish, rd_error,
        output wr_en, rd_en, gen_addr, iter_num, stream_num, burst_length,
        output busy, done, error, timeout, err_count
    );

    modport slave (
        output start, base_addr, num_iters, num_streams, bursts_per_stream, burst_len_cfg,
        output wr_adr_neg, wr_finish, rd_adr_neg, rd_finish, rd_error,
        input  wr_en, rd_en, gen_addr, iter_num, stream_num, burst_length,
        input  busy, done, error, timeout, err_count
    );

endinterface

// File: rtl/ddr_test_sequencer_burst_tracker.sv
// ddr_test_sequencer_burst_tracker: one generator phase (write or read) of a stream.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : arm the phase (enable high next cycle, counters cleared)
//   i_abort        : drop the enable (watchdog fault)
//   i_bursts       : bursts in this phase, already clamped to >= 1
//   i_adr_neg      : address handshake pulse from the generator
//   i_finish       : burst completion pulse from the generator
//   o_en           : generator enable, gated low in the cycle of the last finish
//   o_adr_step     : accepted address handshake (advance the shared address)
//   o_last_done    : accepted finish of the last burst
module ddr_test_sequencer_burst_tracker (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_bursts,
    input  logic        i_adr_neg,
    input  logic        i_finish,
    output logic        o_en,
    output logic        o_adr_step,
    output logic        o_last_done
);
    logic        r_en;
    logic [15:0] r_issued;
    logic [15:0] r_done;
    logic        w_last;
    logic        w_adr_ok;
    logic        w_fin_ok;

    assign w_last   = (r_done == (i_bursts - 16'd1));
    // Handshakes only count while the phase owns the generator.
    assign w_adr_ok = r_en & i_adr_neg & (r_issued != i_bursts);
    assign w_fin_ok = r_en & i_finish;

    // Combinational drop on the last finish so the generator idles instead of
    // launching one more burst before the registered enable falls.
    assign o_en        = r_en & ~(w_last & i_finish);
    assign o_adr_step  = w_adr_ok;
    assign o_last_done = w_fin_ok & w_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_en     <= 1'b0;
            r_issued <= 16'd0;
            r_done   <= 16'd0;
        end else if (i_start) begin
            r_en     <= 1'b1;
            r_issued <= 16'd0;
            r_done   <= 16'd0;
        end else if (i_abort) begin
            r_en     <= 1'b0;
        end else begin
            if (w_adr_ok) begin
                r_issued <= r_issued + 16'd1;
            end
            if (w_fin_ok) begin
                r_done <= r_done + 16'd1;
                if (w_last) begin
                    r_en <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_test_sequencer.sv
// ddr_test_sequencer: runs write-then-read/compare over iterations x streams x bursts.
//   i_clk, i_reset : clock, synchronous active-high reset
//   io_bus         : host config/status and both generator handshakes (master side)
// Each stream writes its bursts from the stream start address, rewinds, reads the
// same addresses back, then the next stream continues from where this one ended.
module ddr_test_sequencer
    import ddr_test_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned BEAT_BYTES_LOG2 = BEAT_BYTES_LOG2_DEF,
    parameter int unsigned TIMEOUT_CYC     = 4096,
    parameter int unsigned ERR_CNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    ddr_test_sequencer_if.master io_bus
);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

    seq_state_e           r_state;
    seq_state_e           w_state_next;
    logic [7:0]           r_iters;
    logic [7:0]           r_streams;
    logic [15:0]          r_bursts;
    logic [7:0]           r_len;
    logic [7:0]           r_iter;
    logic [7:0]           r_stream;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    r_stream_base;
    logic                 r_done;
    logic                 r_error;
    logic                 r_timeout;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [WDOG_W-1:0]    r_wdog;

    logic              w_idle_like;
    logic              w_launch;
    logic              w_running;
    logic              w_any_finish;
    logic              w_wdog_fire;
    logic              w_final;
    logic [ADDR_W-1:0] w_step;
    logic              w_wr_start;
    logic              w_rd_start;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_wr_step;
    logic              w_rd_step;
    logic              w_wr_last;
    logic              w_rd_last;

    assign w_idle_like  = (r_state == StIdle) | (r_state == StDone) | (r_state == StFault);
    assign w_launch     = io_bus.start & w_idle_like;
    assign w_running    = (r_state == StWrRun) | (r_state == StRdRun);
    assign w_any_finish = io_bus.wr_finish | io_bus.rd_finish;
    assign w_wdog_fire  = w_running & ~w_any_finish & (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));
    assign w_final      = (r_stream == (r_streams - 8'd1)) & (r_iter == (r_iters - 8'd1));
    assign w_step       = {{(ADDR_W - 8){1'b0}}, r_len} << BEAT_BYTES_LOG2;

    // Arm a phase on entry so its enable is registered high from the first cycle.
    assign w_wr_start = (w_state_next == StWrRun) & (r_state != StWrRun);
    assign w_rd_start = (w_state_next == StRdRun) & (r_state != StRdRun);

    ddr_test_sequencer_burst_tracker u_wr_trk (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (w_wr_start),
        .i_abort     (w_wdog_fire),
        .i_bursts    (r_bursts),
        .i_adr_neg   (io_bus.wr_adr_neg),
        .i_finish    (io_bus.wr_finish),
        .o_en        (w_wr_en),
        .o_adr_step  (w_wr_step),
        .o_last_done (w_wr_last)
    );

    ddr_test_sequencer_burst_tracker u_rd_trk (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (w_rd_start),
        .i_abort     (w_wdog_fire),
        .i_bursts    (r_bursts),
        .i_adr_neg   (io_bus.rd_adr_neg),
        .i_finish    (io_bus.rd_finish),
        .o_en        (w_rd_en),
        .o_adr_step  (w_rd_step),
        .o_last_done (w_rd_last)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone, StFault: begin
                if (io_bus.start) w_state_next = StWrRun;
            end
            StWrRun: begin
                if (w_wdog_fire)    w_state_next = StFault;
                else if (w_wr_last) w_state_next = StRdRun;
            end
            StRdRun: begin
                if (w_wdog_fire)    w_state_next = StFault;
                else if (w_rd_last) w_state_next = StNext;
            end
            StNext: begin
                w_state_next = w_final ? StDone : StWrRun;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_iters       <= 8'd0;
            r_streams     <= 8'd0;
            r_bursts      <= 16'd0;
            r_len         <= 8'd0;
            r_iter        <= 8'd0;
            r_stream      <= 8'd0;
            r_addr        <= '0;
            r_stream_base <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_timeout     <= 1'b0;
            r_err_cnt     <= '0;
            r_wdog        <= '0;
        end else begin
            r_state <= w_state_next;

            if ((w_state_next != r_state) || w_any_finish) begin
                r_wdog <= '0;
            end else if (w_running) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end

            if (w_launch) begin
                r_iters       <= clamp8(io_bus.num_iters);
                r_streams     <= clamp8(io_bus.num_streams);
                r_bursts      <= clamp16(io_bus.bursts_per_stream);
                r_len         <= clamp8(io_bus.burst_len_cfg);
                r_iter        <= 8'd0;
                r_stream      <= 8'd0;
                r_addr        <= io_bus.base_addr;
                r_stream_base <= io_bus.base_addr;
                r_done        <= 1'b0;
                r_error       <= 1'b0;
                r_timeout     <= 1'b0;
                r_err_cnt     <= '0;
            end else begin
                if (io_bus.rd_error && (r_state != StIdle)) begin
                    r_error <= 1'b1;
                    if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
                if (w_wdog_fire) r_timeout <= 1'b1;

                unique case (r_state)
                    StWrRun: begin
                        // Rewind so the read phase revisits the same addresses.
                        if (w_wr_last)      r_addr <= r_stream_base;
                        else if (w_wr_step) r_addr <= r_addr + w_step;
                    end
                    StRdRun: begin
                        if (w_rd_step) r_addr <= r_addr + w_step;
                    end
                    StNext: begin
                        r_stream_base <= r_addr;
                        if (w_final) begin
                            r_done <= 1'b1;
                        end else if (r_stream == (r_streams - 8'd1)) begin
                            r_stream <= 8'd0;
                            r_iter   <= r_iter + 8'd1;
                        end else begin
                            r_stream <= r_stream + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io_bus.wr_en        = w_wr_en;
    assign io_bus.rd_en        = w_rd_en;
    assign io_bus.gen_addr     = r_addr;
    assign io_bus.iter_num     = r_iter;
    assign io_bus.stream_num   = r_stream;
    assign io_bus.burst_length = r_len;
    assign io_bus.busy         = (r_state == StWrRun) | (r_state == StRdRun) | (r_state == StNext);
    assign io_bus.done         = r_done;
    assign io_bus.error        = r_error;
    assign io_bus.timeout      = r_timeout;
    assign io_bus.err_count    = r_err_cnt;

endmodule

// File: tb/tb_ddr_test_sequencer.sv
// tb_ddr_test_sequencer: randomized generators plus a scoreboard fed by a reference model
// that lists every expected burst (address and tags) and every expected finish.
module tb_ddr_test_sequencer;
    localparam int unsigned TO = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  iter;
        logic [7:0]  strm;
        logic [7:0]  len;
    } burst_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n_wr;
    int   n_rd;
    int   exp_total;
    bit   hold_wr;
    logic prev_wr;
    logic prev_rd;
    burst_t exp_wr[$];
    burst_t exp_rd[$];
    bit     fin_wr[$];
    bit     fin_rd[$];
    burst_t mon_b;
    bit     mon_l;

    ddr_test_sequencer_if #(.ADDR_W(32), .ERR_CNT_W(16)) sif ();

    ddr_test_sequencer #(
        .ADDR_W          (32),
        .BEAT_BYTES_LOG2 (6),
        .TIMEOUT_CYC     (TO),
        .ERR_CNT_W       (16)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write generator: one outstanding burst, random gaps, finish can be withheld.
    initial begin
        sif.wr_adr_neg = 1'b0;
        sif.wr_finish  = 1'b0;
        forever begin
            tick();
            if (sif.wr_en) begin
                repeat ($urandom_range(0, 2)) tick();
                if (sif.wr_en) begin
                    sif.wr_adr_neg = 1'b1;
                    tick();
                    sif.wr_adr_neg = 1'b0;
                    repeat ($urandom_range(0, 3)) tick();
                    while (hold_wr) tick();
                    sif.wr_finish = 1'b1;
                    tick();
                    sif.wr_finish = 1'b0;
                end
            end
        end
    end

    // Read generator.
    initial begin
        sif.rd_adr_neg = 1'b0;
        sif.rd_finish  = 1'b0;
        forever begin
            tick();
            if (sif.rd_en) begin
                repeat ($urandom_range(0, 2)) tick();
                if (sif.rd_en) begin
                    sif.rd_adr_neg = 1'b1;
                    tick();
                    sif.rd_adr_neg = 1'b0;
                    repeat ($urandom_range(0, 3)) tick();
                    sif.rd_finish = 1'b1;
                    tick();
                    sif.rd_finish = 1'b0;
                end
            end
        end
    end

    // Monitor: pop and compare whenever the DUT takes a handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (sif.wr_adr_neg && sif.wr_en) begin
                n_wr++;
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_burst extra burst at addr=%0h", sif.gen_addr);
                end else begin
                    mon_b = exp_wr.pop_front();
                    chk("wr_addr", sif.gen_addr, mon_b.addr);
                    chk("wr_tags", {sif.iter_num, sif.stream_num, sif.burst_length},
                        {mon_b.iter, mon_b.strm, mon_b.len});
                end
            end
            if (sif.rd_adr_neg && sif.rd_en) begin
                n_rd++;
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_burst extra burst at addr=%0h", sif.gen_addr);
                end else begin
                    mon_b = exp_rd.pop_front();
                    chk("rd_addr", sif.gen_addr, mon_b.addr);
                    chk("rd_tags", {sif.iter_num, sif.stream_num, sif.burst_length},
                        {mon_b.iter, mon_b.strm, mon_b.len});
                end
            end
            if (sif.wr_finish && sif.busy && fin_wr.size() != 0) begin
                mon_l = fin_wr.pop_front();
                chk("wr_en_at_finish", sif.wr_en, !mon_l);
            end
            if (sif.rd_finish && sif.busy && fin_rd.size() != 0) begin
                mon_l = fin_rd.pop_front();
                chk("rd_en_at_finish", sif.rd_en, !mon_l);
            end
            if (sif.wr_en && !prev_wr) chk("gap_before_wr", prev_rd, 1'b0);
            if (sif.rd_en && !prev_rd) chk("gap_before_rd", prev_wr, 1'b0);
        end
        prev_wr <= sif.wr_en;
        prev_rd <= sif.rd_en;
    end

    // Reference model: enumerate the whole run, then pulse start.
    task automatic start_run(input logic [31:0] base, input logic [7:0] it, input logic [7:0] st,
                             input logic [15:0] bu, input logic [7:0] ln);
        int ni, ns, nb;
        logic [7:0]  nl;
        logic [31:0] a, sb, step;
        burst_t e;
        ni = (it == 0) ? 1 : int'(it);
        ns = (st == 0) ? 1 : int'(st);
        nb = (bu == 0) ? 1 : int'(bu);
        nl = (ln == 0) ? 8'd1 : ln;
        step = 32'(nl) * 32'd64;
        exp_wr.delete(); exp_rd.delete(); fin_wr.delete(); fin_rd.delete();
        a = base;
        for (int i = 0; i < ni; i++) begin
            for (int s = 0; s < ns; s++) begin
                sb = a;
                for (int b = 0; b < nb; b++) begin
                    e.addr = a; e.iter = 8'(i); e.strm = 8'(s); e.len = nl;
                    exp_wr.push_back(e);
                    fin_wr.push_back(b == nb - 1);
                    a = a + step;
                end
                for (int b = 0; b < nb; b++) begin
                    e.addr = sb + 32'(b) * step; e.iter = 8'(i); e.strm = 8'(s); e.len = nl;
                    exp_rd.push_back(e);
                    fin_rd.push_back(b == nb - 1);
                end
            end
        end
        exp_total = ni * ns * nb;
        n_wr = 0;
        n_rd = 0;
        sif.base_addr = base;
        sif.num_iters = it;
        sif.num_streams = st;
        sif.bursts_per_stream = bu;
        sif.burst_len_cfg = ln;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
    endtask

    task automatic wait_end(input int exp_err);
        int n;
        n = 0;
        while (!sif.done && !sif.timeout && n < 5000) begin
            tick();
            n++;
        end
        chk("run_done", sif.done, 1'b1);
        chk("run_timeout", sif.timeout, 1'b0);
        chk("run_busy", sif.busy, 1'b0);
        chk("err_count", sif.err_count, 64'(exp_err));
        chk("error_flag", sif.error, exp_err != 0);
        chk("wr_bursts", 64'(n_wr), 64'(exp_total));
        chk("rd_bursts", 64'(n_rd), 64'(exp_total));
        chk("fin_left", 64'(fin_wr.size() + fin_rd.size()), 64'd0);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; n_wr = 0; n_rd = 0; exp_total = 0; hold_wr = 1'b0;
        reset = 1'b1;
        sif.start = 1'b0; sif.rd_error = 1'b0; sif.base_addr = '0; sif.num_iters = '0;
        sif.num_streams = '0; sif.bursts_per_stream = '0; sif.burst_len_cfg = '0;
        repeat (3) tick();
        chk("rst_outputs", {sif.wr_en, sif.rd_en, sif.busy, sif.done, sif.error, sif.timeout},
            6'd0);
        chk("rst_addr", sif.gen_addr, 32'd0);
        chk("rst_tags", {sif.iter_num, sif.stream_num, sif.burst_length, sif.err_count}, 40'd0);
        reset = 1'b0;
        tick();

        // Basic single stream.
        start_run(32'h0000_1000, 8'd1, 8'd1, 16'd4, 8'd16);
        wait_end(0);

        // Stream/iteration sequencing.
        start_run(32'h0000_0000, 8'd2, 8'd3, 16'd2, 8'd1);
        wait_end(0);

        // Read mismatches do not stop the run.
        start_run(32'h0000_4000, 8'd1, 8'd1, 16'd8, 8'd4);
        n = 0;
        while (!sif.rd_en && n < 500) begin tick(); n++; end
        chk("rd_phase_reached", sif.rd_en, 1'b1);
        for (int k = 0; k < 3; k++) begin
            sif.rd_error = 1'b1; tick();
            sif.rd_error = 1'b0; tick();
        end
        wait_end(3);

        // Address wrap at the top of the space.
        start_run(32'hFFFF_FF80, 8'd1, 8'd1, 16'd3, 8'd1);
        wait_end(0);

        // Watchdog: withhold the first write finish.
        hold_wr = 1'b1;
        start_run(32'h0000_2000, 8'd1, 8'd1, 16'd4, 8'd4);
        n = 0;
        while (!sif.timeout && n < 300) begin tick(); n++; end
        chk("timeout_set", sif.timeout, 1'b1);
        chk("timeout_latency", (n >= int'(TO) - 2) && (n <= int'(TO) + 3), 1'b1);
        chk("fault_outputs", {sif.wr_en, sif.rd_en, sif.busy, sif.done}, 4'd0);
        hold_wr = 1'b0;
        repeat (20) tick();
        start_run(32'h0000_8000, 8'd1, 8'd2, 16'd2, 8'd2);
        wait_end(0);

        // Reset mid write phase.
        start_run(32'h0000_3000, 8'd1, 8'd2, 16'd8, 8'd8);
        n = 0;
        while (n_wr < 2 && n < 500) begin tick(); n++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_outputs", {sif.wr_en, sif.rd_en, sif.busy, sif.done}, 4'd0);
        chk("midrst_addr", sif.gen_addr, 32'd0);
        chk("midrst_tags", {sif.iter_num, sif.stream_num, sif.burst_length}, 24'd0);
        repeat (20) tick();

        // Start while busy is ignored; config changes are not sampled.
        start_run(32'h0000_5000, 8'd1, 8'd1, 16'd4, 8'd2);
        repeat (6) tick();
        sif.base_addr = 32'h0000_9000;
        sif.bursts_per_stream = 16'd1;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        wait_end(0);

        // Randomized configurations, including zero-clamped fields.
        for (int r = 0; r < 4; r++) begin
            start_run($urandom & 32'hFFFF_FFC0, 8'($urandom_range(0, 2)),
                      8'($urandom_range(0, 3)), 16'($urandom_range(0, 4)),
                      8'($urandom_range(0, 8)));
            wait_end(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
